// File: rtl/div_radix2.sv
// ---------------------------------------------------------------------------
// div_radix2 : multi-cycle radix-2 restoring divider for DIV / DIVU.
//
// One quotient bit is produced per clock. The result is packed as
// {remainder, quotient} for the HI/LO write-back.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend (sampled only when an operation is accepted)
//   opdata2_i     divisor  (sampled only when an operation is accepted)
//   start_i       level request, held by the requester until ready_o
//   annul_i       cancels an operation that is still iterating
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
//
// Optional build macro
//   DIV_EARLY_EXIT_EN : finish in the first iteration cycle when
//                       |divisor| > |dividend| (quotient 0, remainder =
//                       dividend). The result is identical either way.
// ---------------------------------------------------------------------------
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_BY_ZERO = 2'd1,
    ST_ON      = 2'd2,
    ST_END     = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH:0]     work_q, work_d;     // {partial remainder, dividend/quotient}
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic                 neg_dd_q, neg_dd_d; // dividend was negative (signed mode)
  logic                 neg_dr_q, neg_dr_d; // divisor was negative (signed mode)
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic [WIDTH-1:0]     abs_dd_s;
  logic [WIDTH-1:0]     abs_dr_s;
  logic [2*WIDTH:0]     shifted_s;
  logic [WIDTH+1:0]     trial_s;
  logic [2*WIDTH:0]     iter_s;
  logic                 early_s;

  // Sign fix-up: quotient negative when signs differ, remainder follows dividend.
  function automatic logic [2*WIDTH-1:0] fixup(
    input logic             neg_dd,
    input logic             neg_dr,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] rem
  );
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    q = (neg_dd ^ neg_dr) ? (~quo + WIDTH'(1)) : quo;
    r = neg_dd ? (~rem + WIDTH'(1)) : rem;
    return {r, q};
  endfunction

  // Operand magnitudes and one restoring-division step.
  always_comb begin
    abs_dd_s  = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    abs_dr_s  = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
    shifted_s = work_q << 1;
    // One extra bit on the trial difference carries the borrow (sign).
    trial_s   = {1'b0, shifted_s[2*WIDTH:WIDTH]} - {2'b00, divisor_q};
    if (!trial_s[WIDTH+1]) begin
      iter_s = {trial_s[WIDTH:0], shifted_s[WIDTH-1:1], 1'b1};
    end else begin
      iter_s = shifted_s;
    end
`ifdef DIV_EARLY_EXIT_EN
    // In the first ON cycle the low half still holds |dividend|.
    early_s = (cnt_q == CW'(0)) && (divisor_q > work_q[WIDTH-1:0]);
`else
    early_s = 1'b0;
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_dd_d  = neg_dd_q;
    neg_dr_d  = neg_dr_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      ST_FREE: begin
        ready_d  = 1'b0;
        result_d = {(2*WIDTH){1'b0}};
        if (start_i && !annul_i) begin
          if (opdata2_i == {WIDTH{1'b0}}) begin
            state_d = ST_BY_ZERO;
          end else begin
            state_d   = ST_ON;
            work_d    = {{(WIDTH+1){1'b0}}, abs_dd_s};
            divisor_d = abs_dr_s;
            neg_dd_d  = signed_div_i & opdata1_i[WIDTH-1];
            neg_dr_d  = signed_div_i & opdata2_i[WIDTH-1];
            cnt_d     = CW'(0);
          end
        end else begin
          state_d = ST_FREE;
        end
      end
      ST_BY_ZERO: begin
        state_d  = ST_END;
        ready_d  = 1'b1;
        result_d = {(2*WIDTH){1'b0}};
      end
      ST_ON: begin
        if (annul_i || !start_i) begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = {(2*WIDTH){1'b0}};
          cnt_d    = CW'(0);
        end else if (early_s) begin
          state_d  = ST_END;
          ready_d  = 1'b1;
          result_d = fixup(neg_dd_q, neg_dr_q, {WIDTH{1'b0}}, work_q[WIDTH-1:0]);
        end else begin
          work_d = iter_s;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            state_d  = ST_END;
            ready_d  = 1'b1;
            result_d = fixup(neg_dd_q, neg_dr_q, iter_s[WIDTH-1:0], iter_s[2*WIDTH-1:WIDTH]);
          end else begin
            state_d = ST_ON;
          end
        end
      end
      ST_END: begin
        if (!start_i) begin
          state_d  = ST_FREE;
          ready_d  = 1'b0;
          result_d = {(2*WIDTH){1'b0}};
        end else begin
          state_d = ST_END;
        end
      end
      default: begin
        state_d  = ST_FREE;
        ready_d  = 1'b0;
        result_d = {(2*WIDTH){1'b0}};
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= CW'(0);
      work_q    <= {(2*WIDTH+1){1'b0}};
      divisor_q <= {WIDTH{1'b0}};
      neg_dd_q  <= 1'b0;
      neg_dr_q  <= 1'b0;
      result_q  <= {(2*WIDTH){1'b0}};
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_dd_q  <= neg_dd_d;
      neg_dr_q  <= neg_dr_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_radix2.sv
// ---------------------------------------------------------------------------
// tb_div_radix2 : directed self-checking bench for div_radix2.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_div_radix2;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int errors;
  int checks;

  div_radix2 #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_EARLY_EXIT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 33;
`endif

  // Raise start with the given operands and count rising edges until ready_o.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        lat = n;
        break;
      end
    end
    res = result_o;
  endtask

  // Drop start after a result and let END return to FREE.
  task automatic release_start();
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    checks++;
    if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", result_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat; logic [63:0] res;
    do_div(1'b0, 32'd100, 32'd7, lat, res);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL udiv_latency got=%0d exp=33", lat); end
    checks++;
    if (res !== 64'h00000002_0000000E) begin errors++; $display("FAIL udiv_result got=%h exp=%h", res, 64'h00000002_0000000E); end
    release_start();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL udiv_release got ready=%b result=%h exp ready=0 result=0", ready_o, result_o);
    end
  endtask

  task automatic test_signed();
    int lat; logic [63:0] res;
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++; $display("FAIL sdiv_m7_2 got lat=%0d res=%h exp lat=33 res=%h", lat, res, 64'hFFFFFFFF_FFFFFFFD);
    end
    release_start();
    do_div(1'b1, 32'd7, 32'hFFFFFFFE, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000001_FFFFFFFD) begin
      errors++; $display("FAIL sdiv_7_m2 got lat=%0d res=%h exp lat=33 res=%h", lat, res, 64'h00000001_FFFFFFFD);
    end
    release_start();
  endtask

  task automatic test_div_zero();
    int lat; logic [63:0] res;
    do_div(1'b0, 32'h00001234, 32'd0, lat, res);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL divzero_latency got=%0d exp=2", lat); end
    checks++;
    if (res !== 64'd0) begin errors++; $display("FAIL divzero_result got=%h exp=0", res); end
    release_start();
  endtask

  task automatic test_overflow();
    int lat; logic [63:0] res;
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000000_80000000) begin
      errors++; $display("FAIL sdiv_overflow got lat=%0d res=%h exp lat=33 res=%h", lat, res, 64'h00000000_80000000);
    end
    release_start();
  endtask

  task automatic test_annul();
    int lat; logic [63:0] res; int seen;
    seen = 0;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    // Edge 1 accepts, edge k performs iteration k-2: annul sampled at iteration 10.
    repeat (11) begin @(posedge clk); #1; if (ready_o) seen++; end
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk); #1; if (ready_o) seen++;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) seen++; end
    checks++;
    if (seen !== 0 || result_o !== 64'd0) begin
      errors++; $display("FAIL annul_no_result got ready_cycles=%0d result=%h exp 0 and 0", seen, result_o);
    end
    do_div(1'b0, 32'd9, 32'd3, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000000_00000003) begin
      errors++; $display("FAIL annul_next got lat=%0d res=%h exp lat=33 res=%h", lat, res, 64'h00000000_00000003);
    end
    release_start();
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] res;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++; $display("FAIL rst_mid got ready=%b result=%h exp ready=0 result=0", ready_o, result_o);
    end
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    do_div(1'b0, 32'hFFFFFFFF, 32'd1, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000000_FFFFFFFF) begin
      errors++; $display("FAIL rst_mid_next got lat=%0d res=%h exp lat=33 res=%h", lat, res, 64'h00000000_FFFFFFFF);
    end
    release_start();
  endtask

  task automatic test_early_exit();
    int lat; logic [63:0] res;
    do_div(1'b0, 32'd5, 32'd9, lat, res);
    checks++;
    if (lat !== EARLY_LAT || res !== 64'h00000005_00000000) begin
      errors++; $display("FAIL early_u_5_9 got lat=%0d res=%h exp lat=%0d res=%h", lat, res, EARLY_LAT, 64'h00000005_00000000);
    end
    release_start();
    // -5 / 9 signed: quotient 0, remainder -5.
    do_div(1'b1, 32'hFFFFFFFB, 32'd9, lat, res);
    checks++;
    if (lat !== EARLY_LAT || res !== 64'hFFFFFFFB_00000000) begin
      errors++; $display("FAIL early_s_m5_9 got lat=%0d res=%h exp lat=%0d res=%h", lat, res, EARLY_LAT, 64'hFFFFFFFB_00000000);
    end
    release_start();
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] res;
    do_div(1'b0, 32'd100, 32'd7, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000002_0000000E) begin
      errors++; $display("FAIL b2b_first got lat=%0d res=%h exp lat=33 res=%h", lat, res, 64'h00000002_0000000E);
    end
    release_start();
    // -100 / 7 = -14 rem -2, started on the very next cycle.
    do_div(1'b1, 32'hFFFFFF9C, 32'd7, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'hFFFFFFFE_FFFFFFF2) begin
      errors++; $display("FAIL b2b_second got lat=%0d res=%h exp lat=33 res=%h", lat, res, 64'hFFFFFFFE_FFFFFFF2);
    end
    release_start();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_reset_mid();
    test_early_exit();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_radix2.md
Name: div_radix2

Overview:
- Multi-cycle 32-bit radix-2 restoring divider; the functional unit that serves the execute-stage ALU for DIV/DIVU.
- Driven from the ALU's start/signed/operand/cancel signals; produces the 64-bit result written to HI/LO.
- Result packing: HI = remainder in [63:32], LO = quotient in [31:0].
- While busy, the ALU holds div_stall high until ready_o is seen.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH; iteration count = WIDTH.

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset; one clock, synchronous, active-high
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- start_i  in  1  request; level, held high by requester until it sees ready_o
- annul_i  in  1  cancel (exception in MEM); aborts operation in progress
- result_o  out  2*WIDTH  {remainder, quotient}; registered
- ready_o  out  1  result valid; registered

Behaviour:
- Reset values:
  - state = FREE
  - ready_o = 0
  - result_o = 0
  - iteration counter = 0
  - internal dividend/divisor/partial-remainder registers = 0
- rst dominates every other input; reset mid-operation returns to FREE with no result.
- States: FREE, BY_ZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, divisor==0 -> BY_ZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON:
    - latch operands; signed mode latches absolute values plus the two sign bits;
    - clear the 2*WIDTH+1-bit working register to {0, |dividend|};
    - counter = 0.
  - Otherwise stay in FREE; ready_o = 0.
- BY_ZERO: unconditionally -> END with working result = 0.
- ON, one iteration per cycle:
  - shift working register left 1;
  - trial-subtract divisor from the upper half;
  - if non-negative, keep the difference and set LSB=1; else restore and set LSB=0.
  - counter increments; after iteration WIDTH-1 -> END.
  - annul_i=1 in ON -> FREE immediately: ready_o stays 0, result discarded.
  - start_i dropping in ON also aborts -> FREE.
- Sign fix-up, applied on the ON->END edge in signed mode:
  - quotient negated (two's complement) when dividend and divisor signs differ;
  - remainder takes the sign of the dividend.
  - Unsigned mode: no fix-up.
- END:
  - ready_o = 1 and result_o valid.
  - Stays in END while start_i = 1.
  - start_i = 0 -> FREE; ready_o cleared and result_o cleared to 0 on that edge.
  - annul_i is ignored in END.
- Latency, counted in rising edges from the edge that samples start_i in FREE to ready_o high:
  - normal: WIDTH+1 = 33;
  - divide-by-zero: 2.
- Overflow case: 0x80000000 / 0xFFFFFFFF (signed) yields quotient 0x80000000, remainder 0; no trap.
- Back-to-back operations: after END->FREE, a new start_i is accepted on the next edge; at least one idle FREE cycle lies between results.
- Operand inputs are don't-care outside the FREE-sampling edge.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in the first ON cycle (counter==0), if |divisor| > |dividend| (unsigned compare of the latched magnitudes), go directly to END with:
  - quotient = 0;
  - remainder = original dividend, sign preserved.
  - Latency in that case is 2 edges. All other cases are unchanged.
- Not defined: every nonzero-divisor operation takes the full 33 edges.
- Results are bit-identical either way.

Test Plan:
- Unsigned 100 / 7 (signed_div_i=0, start held) -> ready_o high exactly 33 edges after start; result_o = 0x00000002_0000000E; drop start -> next edge ready_o=0, result_o=0.
- Signed 0xFFFFFFF9 / 2 (-7/2) -> result_o = 0xFFFFFFFF_FFFFFFFD (rem -1, quo -3); signed 7 / -2 -> 0x00000001_FFFFFFFD.
- Divisor 0 (dividend 0x1234) -> ready_o after 2 edges, result_o = 0; signed 0x80000000 / 0xFFFFFFFF -> 0x00000000_80000000 after 33 edges.
- Start 100/7, assert annul_i for one cycle at iteration 10 -> ready_o never rises, state FREE; then 9/3 -> result 0x00000000_00000003 after 33 edges.
- Assert rst at iteration 20 of a divide -> next edge ready_o=0, result_o=0, FREE; an immediately following 0xFFFFFFFF/1 unsigned completes correctly = 0x00000000_FFFFFFFF.
- DIV_EARLY_EXIT_EN defined: unsigned 5 / 9 -> ready_o after 2 edges, result 0x00000005_00000000; undefined -> same result after 33 edges.
